// File: rtl/pixel_stream_pkg.sv
// Shared definitions for the packed 24-bit RGB pixel stream.
// Both the packer and the unpacker use these. In a packed stream,
// four 24-bit pixels occupy three 32-bit words.
//
// Contents:
//   R/G/B byte-lane positions inside a 24-bit pixel
//   WORDS_PER_GROUP / PIXELS_PER_GROUP  packing ratio
//   phase_t                             word-within-group phase
//   pixel_t                             one unpacked pixel plus its markers
package pixel_stream_pkg;

    localparam int R_MSB = 23;
    localparam int R_LSB = 16;
    localparam int G_MSB = 15;
    localparam int G_LSB = 8;
    localparam int B_MSB = 7;
    localparam int B_LSB = 0;

    localparam int WORDS_PER_GROUP  = 3;
    localparam int PIXELS_PER_GROUP = 4;

    // PH2B is the extra cycle in which the fourth pixel is emitted
    // from leftover bits, without consuming a word.
    typedef enum logic [1:0] {
        PH0,
        PH1,
        PH2,
        PH2B
    } phase_t;

    typedef struct packed {
        logic [23:0] rgb;
        logic        sof;
        logic        eol;
    } pixel_t;

endpackage

// File: rtl/pixel_unpacker_if.sv
// Packed 32-bit AXI-Stream carrying 24-bit pixels, four pixels per
// three words.
//
// Signals:
//   tdata   packed pixel bytes, little-endian
//   tkeep   byte enables (producers always drive 4'hF)
//   tlast   end of line, on the third word of a group
//   tuser   start of frame, on the first word of a group
//   tvalid  word valid
//   tready  word accepted when high together with tvalid
// Modports: master drives the stream; slave consumes it.
interface pixel_unpacker_if;

    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;
    logic        tuser;
    logic        tvalid;
    logic        tready;

    modport master (
        output tdata, tkeep, tlast, tuser, tvalid,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tlast, tuser, tvalid,
        output tready
    );

endinterface

// File: rtl/pixel_out_reg.sv
// One-entry valid/ready output stage for unpacked pixels.
// It holds one pixel together with its sof/eol markers. While the
// pixel waits for the consumer, the stored pixel stays unchanged.
//
// Ports:
//   aclk, areset  clock and asynchronous active-high reset
//   load_i        capture pix_i; the caller loads only when the slot is free
//   pix_i         pixel to capture
//   ready_i       downstream accepts the held pixel
//   pix_o         held pixel
//   valid_o       held pixel is valid
module pixel_out_reg
    import pixel_stream_pkg::*;
(
    input  logic   aclk,
    input  logic   areset,
    input  logic   load_i,
    input  pixel_t pix_i,
    input  logic   ready_i,
    output pixel_t pix_o,
    output logic   valid_o
);

    pixel_t pix_q;
    logic   valid_q;

    // A load takes priority over a drain. The caller loads only when
    // the slot is empty or is being drained in the same cycle, so a
    // held pixel is never overwritten.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            pix_q   <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            pix_q   <= pix_i;
            valid_q <= 1'b1;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign pix_o   = pix_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/pixel_unpacker.sv
// Unpacks the packed 24-bit RGB stream (4 pixels in 3 words) into one
// pixel per handshake, with sof/eol markers and misalignment detection.
//
// Build option: define PIXEL_UNPACKER_LINE_CHECK_EN to enable the
// line-length checker that drives err_line. Without it, err_line is 0.
//
// Parameters:
//   X_SIZE     expected pixels per line (multiple of 4); line checker only
// Ports:
//   aclk, areset  clock and asynchronous active-high reset
//   in_stream     packed input stream (slave side)
//   r, g, b       unpacked pixel
//   sof, eol      first pixel of frame / last pixel of line
//   valid, ready  output pixel handshake
//   err_align     one-cycle pulse on a misplaced tuser or tlast
//   err_line      one-cycle pulse on a line-length mismatch
module pixel_unpacker
    import pixel_stream_pkg::*;
#(
    parameter int X_SIZE = 640
) (
    input  logic             aclk,
    input  logic             areset,
    pixel_unpacker_if.slave  in_stream,
    output logic [7:0]       r,
    output logic [7:0]       g,
    output logic [7:0]       b,
    output logic             sof,
    output logic             eol,
    output logic             valid,
    input  logic             ready,
    output logic             err_align,
    output logic             err_line
);

    phase_t      state_q, state_d, effPhase;
    logic [23:0] resid_q, resid_d;
    logic        eolPend_q, eolPend_d;
    logic        errAlign_q, errAlign_d;
    logic        canLoad, accept, load, misUser, misLast;
    logic [31:0] word;
    pixel_t      pixIn, pixOut;
    logic        unusedCfg;

    // tkeep is always all-ones, so it is ignored. This flag also keeps
    // the packing-ratio constants and X_SIZE referenced in every build.
    assign unusedCfg = (^in_stream.tkeep) ||
                       ((X_SIZE % PIXELS_PER_GROUP) != 0) ||
                       (WORDS_PER_GROUP != 3);

    assign word    = in_stream.tdata;
    assign canLoad = !valid || ready;
    assign accept  = in_stream.tvalid && in_stream.tready;

    assign in_stream.tready = !areset && (state_q != PH2B) && canLoad;

    // Next-state and pixel assembly.
    // A misplaced tuser restarts the group, so the word is decoded as
    // W0 (effPhase = PH0). A tlast on anything but W2 of the effective
    // group closes the line early and returns to PH0.
    always_comb begin
        state_d    = state_q;
        resid_d    = resid_q;
        eolPend_d  = eolPend_q;
        errAlign_d = 1'b0;
        load       = 1'b0;
        misUser    = 1'b0;
        misLast    = 1'b0;
        effPhase   = state_q;
        pixIn      = '0;

        if (state_q == PH2B) begin
            if (canLoad) begin
                load       = 1'b1;
                pixIn.rgb  = resid_q;
                pixIn.eol  = eolPend_q;
                state_d    = PH0;
                resid_d    = '0;
                eolPend_d  = 1'b0;
            end
        end else if (accept) begin
            misUser    = in_stream.tuser && (state_q == PH1 || state_q == PH2);
            effPhase   = misUser ? PH0 : state_q;
            misLast    = in_stream.tlast && (effPhase != PH2);
            load       = 1'b1;
            errAlign_d = misUser || misLast;
            pixIn.sof  = in_stream.tuser && (effPhase == PH0);
            pixIn.eol  = misLast;

            case (effPhase)
                PH0: begin
                    pixIn.rgb = word[23:0];
                    resid_d   = {16'h0, word[31:24]};
                    state_d   = PH1;
                end
                PH1: begin
                    pixIn.rgb = {word[15:0], resid_q[7:0]};
                    resid_d   = {8'h0, word[31:16]};
                    state_d   = PH2;
                end
                default: begin
                    pixIn.rgb = {word[7:0], resid_q[15:0]};
                    resid_d   = word[31:8];
                    eolPend_d = in_stream.tlast;
                    state_d   = PH2B;
                end
            endcase

            if (misLast) begin
                state_d = PH0;
                resid_d = '0;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q    <= PH0;
            resid_q    <= '0;
            eolPend_q  <= 1'b0;
            errAlign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            resid_q    <= resid_d;
            eolPend_q  <= eolPend_d;
            errAlign_q <= errAlign_d;
        end
    end

    pixel_out_reg u_out_reg (
        .aclk    (aclk),
        .areset  (areset),
        .load_i  (load),
        .pix_i   (pixIn),
        .ready_i (ready),
        .pix_o   (pixOut),
        .valid_o (valid)
    );

    assign r         = pixOut.rgb[R_MSB:R_LSB];
    assign g         = pixOut.rgb[G_MSB:G_LSB];
    assign b         = pixOut.rgb[B_MSB:B_LSB];
    assign sof       = pixOut.sof;
    assign eol       = pixOut.eol;
    assign err_align = errAlign_q;

`ifdef PIXEL_UNPACKER_LINE_CHECK_EN
    localparam int CW = $clog2(X_SIZE + 1);

    logic [CW-1:0] lineCount_q, lineCount_d, cntBase, cntNext;
    logic          errLine_q, errLine_d;

    // Counts pixels as they enter the output stage. The error pulse is
    // registered so that it lines up with the offending pixel on valid.
    always_comb begin
        lineCount_d = lineCount_q;
        errLine_d   = 1'b0;
        cntBase     = pixIn.sof ? '0 : lineCount_q;
        cntNext     = cntBase + CW'(1);
        if (load) begin
            if (pixIn.eol) begin
                errLine_d   = (cntNext != CW'(X_SIZE));
                lineCount_d = '0;
            end else if (cntNext == CW'(X_SIZE)) begin
                errLine_d   = 1'b1;
                lineCount_d = '0;
            end else begin
                lineCount_d = cntNext;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            lineCount_q <= '0;
            errLine_q   <= 1'b0;
        end else begin
            lineCount_q <= lineCount_d;
            errLine_q   <= errLine_d;
        end
    end

    assign err_line = errLine_q;
`else
    assign err_line = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_unpacker.sv
// Testbench for pixel_unpacker. Table-driven cycle vectors cover clean
// groups, backpressure and misalignment. Hand-written sequences cover
// mid-group reset and the line-length checker (X_SIZE = 8).
module tb_pixel_unpacker;

    logic       aclk;
    logic       areset;
    logic [7:0] r, g, b;
    logic       sof, eol, valid, ready, err_align, err_line;

    int totalChecks = 0;
    int badChecks   = 0;

    pixel_unpacker_if inS ();

    pixel_unpacker #(.X_SIZE(8)) dut (
        .aclk      (aclk),
        .areset    (areset),
        .in_stream (inS),
        .r         (r),
        .g         (g),
        .b         (b),
        .sof       (sof),
        .eol       (eol),
        .valid     (valid),
        .ready     (ready),
        .err_align (err_align),
        .err_line  (err_line)
    );

    // 100 MHz clock
    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // Safety net against a hung handshake
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic [31:0] tdata;
        logic        tuser;
        logic        tlast;
        logic        tvalid;
        logic        rdy;
        logic        expValid;
        logic [23:0] expRgb;
        logic        expSof;
        logic        expEol;
        logic        expAlign;
        logic        expTready;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [31:0] d, logic tu, logic tl, logic tv, logic rd,
                                logic ev, logic [23:0] er, logic es, logic ee,
                                logic ea, logic et);
        vec_t v;
        v.tdata = d; v.tuser = tu; v.tlast = tl; v.tvalid = tv; v.rdy = rd;
        v.expValid = ev; v.expRgb = er; v.expSof = es; v.expEol = ee;
        v.expAlign = ea; v.expTready = et;
        return v;
    endfunction

    task automatic checkValue(string name, logic [31:0] act, logic [31:0] exp);
        totalChecks++;
        if (act !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(vec_t v);
        inS.tdata  = v.tdata;
        inS.tkeep  = 4'hF;
        inS.tuser  = v.tuser;
        inS.tlast  = v.tlast;
        inS.tvalid = v.tvalid;
        ready      = v.rdy;
    endtask

    task automatic checkOutput(vec_t v, int idx);
        checkValue($sformatf("row%0d valid", idx), 32'(valid), 32'(v.expValid));
        checkValue($sformatf("row%0d tready", idx), 32'(inS.tready), 32'(v.expTready));
        checkValue($sformatf("row%0d err_align", idx), 32'(err_align), 32'(v.expAlign));
        if (v.expValid) begin
            checkValue($sformatf("row%0d rgb", idx), 32'({r, g, b}), 32'(v.expRgb));
            checkValue($sformatf("row%0d sof", idx), 32'(sof), 32'(v.expSof));
            checkValue($sformatf("row%0d eol", idx), 32'(eol), 32'(v.expEol));
        end
    endtask

    task automatic runRows(int first, int last);
        for (int i = first; i <= last; i++) begin
            @(posedge aclk);
            #1;
            applyStimulus(vecs[i]);
            #1;
            checkOutput(vecs[i], i);
        end
    endtask

    task automatic checkResetState(string tag);
        checkValue({tag, " valid"}, 32'(valid), 32'h0);
        checkValue({tag, " rgb"}, 32'({r, g, b}), 32'h0);
        checkValue({tag, " sof/eol"}, 32'({sof, eol}), 32'h0);
        checkValue({tag, " tready"}, 32'(inS.tready), 32'h0);
        checkValue({tag, " errs"}, 32'({err_align, err_line}), 32'h0);
    endtask

    initial begin
        int          idx;
        int          pixCnt;
        int          alignSeen;
        logic [15:0] errMask;
        logic [15:0] expMask;

        // Clean group, ready always high (rows 0-5)
        vecs.push_back(mk(32'h44332211, 1, 0, 1, 1, 0, 24'h000000, 0, 0, 0, 1));
        vecs.push_back(mk(32'h88776655, 0, 0, 1, 1, 1, 24'h332211, 1, 0, 0, 1));
        vecs.push_back(mk(32'hCCBBAA99, 0, 1, 1, 1, 1, 24'h665544, 0, 0, 0, 1));
        vecs.push_back(mk(32'h00000000, 0, 0, 0, 1, 1, 24'h998877, 0, 0, 0, 0));
        vecs.push_back(mk(32'h00000000, 0, 0, 0, 1, 1, 24'hCCBBAA, 0, 1, 0, 1));
        vecs.push_back(mk(32'h00000000, 0, 0, 0, 1, 0, 24'h000000, 0, 0, 0, 1));
        // Same group under backpressure (rows 6-15)
        vecs.push_back(mk(32'h44332211, 1, 0, 1, 1, 0, 24'h000000, 0, 0, 0, 1));
        vecs.push_back(mk(32'h88776655, 0, 0, 1, 0, 1, 24'h332211, 1, 0, 0, 0));
        vecs.push_back(mk(32'h88776655, 0, 0, 1, 0, 1, 24'h332211, 1, 0, 0, 0));
        vecs.push_back(mk(32'h88776655, 0, 0, 1, 1, 1, 24'h332211, 1, 0, 0, 1));
        vecs.push_back(mk(32'hCCBBAA99, 0, 1, 1, 1, 1, 24'h665544, 0, 0, 0, 1));
        vecs.push_back(mk(32'h00000000, 0, 0, 0, 0, 1, 24'h998877, 0, 0, 0, 0));
        vecs.push_back(mk(32'h00000000, 0, 0, 0, 1, 1, 24'h998877, 0, 0, 0, 0));
        vecs.push_back(mk(32'h00000000, 0, 0, 0, 0, 1, 24'hCCBBAA, 0, 1, 0, 0));
        vecs.push_back(mk(32'h00000000, 0, 0, 0, 1, 1, 24'hCCBBAA, 0, 1, 0, 1));
        vecs.push_back(mk(32'h00000000, 0, 0, 0, 1, 0, 24'h000000, 0, 0, 0, 1));
        // tuser on the second word restarts the group (rows 16-21)
        vecs.push_back(mk(32'h03020100, 1, 0, 1, 1, 0, 24'h000000, 0, 0, 0, 1));
        vecs.push_back(mk(32'h07060504, 1, 0, 1, 1, 1, 24'h020100, 1, 0, 0, 1));
        vecs.push_back(mk(32'h0B0A0908, 0, 0, 1, 1, 1, 24'h060504, 1, 0, 1, 1));
        vecs.push_back(mk(32'h0F0E0D0C, 0, 1, 1, 1, 1, 24'h090807, 0, 0, 0, 1));
        vecs.push_back(mk(32'h00000000, 0, 0, 0, 1, 1, 24'h0C0B0A, 0, 0, 0, 0));
        vecs.push_back(mk(32'h00000000, 0, 0, 0, 1, 1, 24'h0F0E0D, 0, 1, 0, 1));
        // tlast on W1 closes the line early (rows 22-25)
        vecs.push_back(mk(32'h13121110, 1, 0, 1, 1, 0, 24'h000000, 0, 0, 0, 1));
        vecs.push_back(mk(32'h17161514, 0, 1, 1, 1, 1, 24'h121110, 1, 0, 0, 1));
        vecs.push_back(mk(32'h1B1A1918, 0, 0, 1, 1, 1, 24'h151413, 0, 1, 1, 1));
        vecs.push_back(mk(32'h00000000, 0, 0, 0, 1, 1, 24'h1A1918, 0, 0, 0, 1));
        // tuser and tlast together in PH1, then a clean group (rows 26-33)
        vecs.push_back(mk(32'h23222120, 1, 1, 1, 1, 0, 24'h000000, 0, 0, 0, 1));
        vecs.push_back(mk(32'h00000000, 0, 0, 0, 1, 1, 24'h222120, 1, 1, 1, 1));
        vecs.push_back(mk(32'h33323130, 0, 0, 1, 1, 0, 24'h000000, 0, 0, 0, 1));
        vecs.push_back(mk(32'h37363534, 0, 0, 1, 1, 1, 24'h323130, 0, 0, 0, 1));
        vecs.push_back(mk(32'h3B3A3938, 0, 1, 1, 1, 1, 24'h353433, 0, 0, 0, 1));
        vecs.push_back(mk(32'h00000000, 0, 0, 0, 1, 1, 24'h383736, 0, 0, 0, 0));
        vecs.push_back(mk(32'h00000000, 0, 0, 0, 1, 1, 24'h3B3A39, 0, 1, 0, 1));
        vecs.push_back(mk(32'h00000000, 0, 0, 0, 1, 0, 24'h000000, 0, 0, 0, 1));

        // Power-on reset
        areset     = 1'b1;
        ready      = 1'b1;
        inS.tdata  = '0;
        inS.tkeep  = 4'hF;
        inS.tuser  = 1'b0;
        inS.tlast  = 1'b0;
        inS.tvalid = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        checkResetState("por");
        areset = 1'b0;

        runRows(0, vecs.size() - 1);

        // Reset after W1 is accepted drops the residual and the pending pixel
        @(posedge aclk);
        #1;
        applyStimulus(vecs[0]);
        @(posedge aclk);
        #1;
        applyStimulus(vecs[1]);
        @(posedge aclk);
        #1;
        areset     = 1'b1;
        inS.tvalid = 1'b0;
        #1;
        checkResetState("midreset");
        repeat (2) @(posedge aclk);
        #1;
        checkResetState("midreset hold");
        areset = 1'b0;
        runRows(0, 5);

        // Line of 12 pixels (3 groups), eol only on pixel 12, X_SIZE = 8
        idx       = 0;
        pixCnt    = 0;
        alignSeen = 0;
        errMask   = '0;
        ready     = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(posedge aclk);
            #1;
            if (valid && ready) begin
                pixCnt++;
                if (err_line && pixCnt < 16) errMask[pixCnt] = 1'b1;
            end else if (err_line) begin
                errMask[0] = 1'b1;
            end
            if (err_align) alignSeen++;
            if (idx < 9) begin
                inS.tdata  = 32'h01010101 * (idx + 1);
                inS.tuser  = (idx == 0);
                inS.tlast  = (idx == 8);
                inS.tvalid = 1'b1;
            end else begin
                inS.tvalid = 1'b0;
                inS.tuser  = 1'b0;
                inS.tlast  = 1'b0;
            end
            #1;
            if (inS.tvalid && inS.tready) idx++;
        end
`ifdef PIXEL_UNPACKER_LINE_CHECK_EN
        expMask = 16'h1100;
`else
        expMask = 16'h0000;
`endif
        checkValue("line words accepted", 32'(idx), 32'd9);
        checkValue("line pixel count", 32'(pixCnt), 32'd12);
        checkValue("line err_line pixels", 32'(errMask), 32'(expMask));
        checkValue("line err_align pulses", 32'(alignSeen), 32'd0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
